// File: rtl/otter_reg_file.sv
// OTTER architectural register file: x0 hardwired to zero, reset runs a sequential clear of x1..x(DEPTH-1). Optional macro: REG_FILE_BYPASS_EN.
// Latency: reads are combinational (zero-cycle); writes land on the rising CLK edge; the clear takes DEPTH-1 edges after RST falls.
// Backpressure: none; BUSY=1 during the clear, and in that time WE is ignored and RS1/RS2 are forced to 0.
module otter_reg_file #(
    parameter  int WIDTH  = 32,
    parameter  int DEPTH  = 32,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WA,
    input  logic [WIDTH-1:0]  WD,
    input  logic [ADDR_W-1:0] ADR1,
    input  logic [ADDR_W-1:0] ADR2,
    output logic [WIDTH-1:0]  RS1,
    output logic [WIDTH-1:0]  RS2,
    output logic              BUSY
);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ZERO_IDX = '0;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   clr_idx, clr_idx_nxt;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_wa;
    logic [WIDTH-1:0]    mem_wd;
    logic                user_wr;

    logic [WIDTH-1:0]    mem [DEPTH];

    // State is deliberately left unreset before the first RST edge; the system must assert RST at power-up.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= CLEAR;
            clr_idx <= ZERO_IDX + 1'b1;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
        end
    end

    assign user_wr = WE && (WA != ZERO_IDX);

    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        mem_we      = 1'b0;
        mem_wa      = WA;
        mem_wd      = WD;
        case (state)
            CLEAR: begin
                mem_we      = !RST;
                mem_wa      = clr_idx;
                mem_wd      = '0;
                clr_idx_nxt = clr_idx + 1'b1;
                if (clr_idx == LAST_IDX) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                mem_we = user_wr && !RST;
            end
            default: begin
                state_nxt = CLEAR;
            end
        endcase
    end

    // Plain array with async read / sync write so it maps to distributed RAM or flops.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    assign BUSY = (state == CLEAR);

    function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] adr);
        logic [WIDTH-1:0] dat;
        if (BUSY || adr == ZERO_IDX) begin
            dat = '0;
        end else begin
`ifdef REG_FILE_BYPASS_EN
            // Write-through: the value being written this cycle is visible before the edge.
            if (user_wr && WA == adr) begin
                dat = WD;
            end else begin
                dat = mem[adr];
            end
`else
            dat = mem[adr];
`endif
        end
        return dat;
    endfunction

    assign RS1 = read_port(ADR1);
    assign RS2 = read_port(ADR2);

endmodule

// File: tb/tb_otter_reg_file.sv
// Self-checking bench for otter_reg_file: reset/clear timing, directed vectors, random traffic vs a reference model.
module tb_otter_reg_file;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic              WE  = 1'b0;
    logic [ADDR_W-1:0] WA  = '0;
    logic [WIDTH-1:0]  WD  = '0;
    logic [ADDR_W-1:0] ADR1 = '0;
    logic [ADDR_W-1:0] ADR2 = '0;
    logic [WIDTH-1:0]  RS1;
    logic [WIDTH-1:0]  RS2;
    logic              BUSY;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] model [DEPTH];

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] wa;
        logic [WIDTH-1:0]  wd;
        logic [ADDR_W-1:0] adr1;
        logic [ADDR_W-1:0] adr2;
        logic [WIDTH-1:0]  exp1;
        logic [WIDTH-1:0]  exp2;
    } vec_t;

    vec_t vecs [9];

    otter_reg_file #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .WE   (WE),
        .WA   (WA),
        .WD   (WD),
        .ADR1 (ADR1),
        .ADR2 (ADR2),
        .RS1  (RS1),
        .RS2  (RS2),
        .BUSY (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Counts edges until BUSY falls; the bound turns a stuck FSM into a count mismatch.
    task automatic wait_clear(output int cnt);
        cnt = 0;
        while (BUSY === 1'b1 && cnt < 100) begin
            step();
            cnt++;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    function automatic logic [WIDTH-1:0] model_read(input logic [ADDR_W-1:0] adr);
        if (adr == 0) return '0;
        if (BYP && WE && WA != 0 && WA == adr) return WD;
        return model[adr];
    endfunction

    task automatic write_reg(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
        WE = 1'b1; WA = a; WD = d;
        step();
        WE = 1'b0;
        if (a != 0) model[a] = d;
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        step();
        RST = 1'b0;
        model_clear();
    endtask

    initial begin
        int cnt;
        logic [WIDTH-1:0] e1, e2;

        // Power-up reset and reset-state outputs.
        ADR1 = 5'd5; ADR2 = 5'd31;
        RST = 1'b1;
        step();
        check("reset_busy", {31'd0, BUSY}, 32'd1);
        check("reset_rs1", RS1, 32'd0);
        check("reset_rs2", RS2, 32'd0);
        RST = 1'b0;
        model_clear();
        wait_clear(cnt);
        check("powerup_clear_cycles", cnt, 32'd31);

        // Preloaded value must be wiped by a later reset.
        write_reg(5'd5, 32'hDEADBEEF);
        ADR1 = 5'd5; #1;
        check("preload_x5", RS1, 32'hDEADBEEF);
        pulse_reset();
        check("busy_after_pulse", {31'd0, BUSY}, 32'd1);
        check("rs1_during_clear", RS1, 32'd0);
        wait_clear(cnt);
        check("clear_cycles", cnt, 32'd31);
        check("busy_low_after_clear", {31'd0, BUSY}, 32'd0);
        for (int i = 1; i < DEPTH; i++) begin
            ADR1 = ADDR_W'(i); ADR2 = ADDR_W'(DEPTH - i);
            #1;
            check($sformatf("cleared_x%0d", i), RS1, 32'd0);
        end

        // Directed vectors: expectations hold pre-edge values in the same cycle.
        vecs[0] = '{1'b1, 5'd7,  32'h12345678, 5'd7,  5'd7,  BYP ? 32'h12345678 : 32'h0, BYP ? 32'h12345678 : 32'h0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h12345678, 32'h12345678};
        vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd7,  32'h0, 32'h12345678};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0, 32'h0};
        vecs[4] = '{1'b1, 5'd3,  32'h11,       5'd0,  5'd3,  32'h0, BYP ? 32'h11 : 32'h0};
        vecs[5] = '{1'b1, 5'd3,  32'h22,       5'd3,  5'd7,  BYP ? 32'h22 : 32'h11, 32'h12345678};
        vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd3,  32'h22, 32'h22};
        vecs[7] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd30, BYP ? 32'hA5A5A5A5 : 32'h0, 32'h0};
        vecs[8] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd5,  32'hA5A5A5A5, 32'h0};
        for (int i = 0; i < 9; i++) begin
            WE = vecs[i].we; WA = vecs[i].wa; WD = vecs[i].wd;
            ADR1 = vecs[i].adr1; ADR2 = vecs[i].adr2;
            #1;
            check($sformatf("vec%0d_rs1", i), RS1, vecs[i].exp1);
            check($sformatf("vec%0d_rs2", i), RS2, vecs[i].exp2);
            step();
            if (vecs[i].we && vecs[i].wa != 0) model[vecs[i].wa] = vecs[i].wd;
        end
        WE = 1'b0;

        // Random IDLE traffic against the array model.
        for (int i = 0; i < 300; i++) begin
            WE = 1'($urandom_range(0, 1));
            WA = ADDR_W'($urandom_range(0, DEPTH - 1));
            WD = $urandom;
            ADR1 = ($urandom_range(0, 3) == 0) ? WA : ADDR_W'($urandom_range(0, DEPTH - 1));
            ADR2 = ADDR_W'($urandom_range(0, DEPTH - 1));
            #1;
            e1 = model_read(ADR1);
            e2 = model_read(ADR2);
            check($sformatf("rand%0d_rs1", i), RS1, e1);
            check($sformatf("rand%0d_rs2", i), RS2, e2);
            step();
            if (WE && WA != 0) model[WA] = WD;
        end
        WE = 1'b0;
        check("busy_idle_after_random", {31'd0, BUSY}, 32'd0);

        // Mid-clear reset: restart at clr_idx 10, full 31 edges follow the second release.
        write_reg(5'd20, 32'hCAFEF00D);
        pulse_reset();
        repeat (9) step();
        check("busy_mid_clear", {31'd0, BUSY}, 32'd1);
        pulse_reset();
        wait_clear(cnt);
        check("restart_clear_cycles", cnt, 32'd31);
        ADR1 = 5'd20; ADR2 = 5'd9; #1;
        check("x20_after_restart", RS1, 32'd0);
        check("x9_after_restart", RS2, 32'd0);

        // Writes during clear are ignored and never bypassed.
        write_reg(5'd4, 32'h55);
        RST = 1'b1;
        step();
        RST = 1'b0;
        model_clear();
        WE = 1'b1; WA = 5'd4; WD = 32'hAA; ADR1 = 5'd4; ADR2 = 5'd4;
        repeat (20) step();
        check("rs1_no_bypass_busy", RS1, 32'd0);
        wait_clear(cnt);
        check("clear_cycles_with_we", cnt, 32'd11);
        WE = 1'b0; #1;
        check("x4_after_clear_we", RS1, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
